// File: rtl/soc_system_camera_pwr_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : soc_system_camera_pwr_seq                                     |
// | Function : camera power/reset/XCLK sequencer with Avalon-MM registers    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module soc_system_camera_pwr_seq #(
   parameter int CLK_DIV   = 50,
   parameter int T_PWR_DEF = 1000,
   parameter int T_RDY_DEF = 20000,
   parameter int T_OFF     = 10
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        cam_pwdn_n,
   output logic        cam_rst_n,
   output logic        cam_xclk_en,
   output logic        ready,
   output logic        irq
);

   localparam int              c_PW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [c_PW-1:0] c_PRE_MAX  = c_PW'(CLK_DIV - 1);
   localparam logic [15:0]     c_T_OFF    = 16'(T_OFF);
   localparam logic [15:0]     c_TPWR_DEF = 16'(T_PWR_DEF);
   localparam logic [15:0]     c_TRDY_DEF = 16'(T_RDY_DEF);

   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_PWRUP  = 3'd1,
      S_RSTREL = 3'd2,
      S_READY  = 3'd3,
      S_SHUTDN = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next;
   logic [15:0]     r_timer;
   logic [c_PW-1:0] r_presc;
   logic [15:0]     w_load;
   logic            w_done;

   logic            r_en;
   logic [15:0]     r_t_pwr;
   logic [15:0]     r_t_rdy;
   logic            r_irq_pend;
   logic            r_irq_en;

   logic            r_pwdn_n, r_rst_n, r_xclk_en, r_ready;
   logic            w_pwdn_n, w_rst_n, w_xclk_en, w_ready;
   logic            w_busy;
   logic            w_wr;
   logic            w_irq_set;

   assign w_wr      = chipselect & ~write_n;
   assign w_done    = (r_timer == 16'd0);
   assign w_irq_set = (w_next == S_READY) && (r_state != S_READY);
   assign w_busy    = (r_state == S_PWRUP) || (r_state == S_RSTREL) || (r_state == S_SHUTDN);

   // Loss of en pre-empts timer completion in every powered state.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_OFF:    if (r_en) w_next = S_PWRUP;
         S_PWRUP:  if (!r_en) w_next = S_SHUTDN;
                   else if (w_done) w_next = S_RSTREL;
         S_RSTREL: if (!r_en) w_next = S_SHUTDN;
                   else if (w_done) w_next = S_READY;
         S_READY:  if (!r_en) w_next = S_SHUTDN;
         S_SHUTDN: if (w_done) w_next = S_OFF;
         default:  w_next = S_OFF;
      endcase
   end

   // Timer load and pin levels are decoded from the upcoming state so they
   // register on the same edge as the state itself.
   always_comb begin
      w_load    = 16'd0;
      w_pwdn_n  = 1'b0;
      w_rst_n   = 1'b0;
      w_xclk_en = 1'b0;
      w_ready   = 1'b0;
      case (w_next)
         S_PWRUP: begin
            w_load    = r_t_pwr;
            w_pwdn_n  = 1'b1;
            w_xclk_en = 1'b1;
         end
         S_RSTREL: begin
            w_load    = r_t_rdy;
            w_pwdn_n  = 1'b1;
            w_rst_n   = 1'b1;
            w_xclk_en = 1'b1;
         end
         S_READY: begin
            w_pwdn_n  = 1'b1;
            w_rst_n   = 1'b1;
            w_xclk_en = 1'b1;
            w_ready   = 1'b1;
         end
         S_SHUTDN: begin
            w_load    = c_T_OFF;
            w_pwdn_n  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_OFF;
         r_pwdn_n  <= 1'b0;
         r_rst_n   <= 1'b0;
         r_xclk_en <= 1'b0;
         r_ready   <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_pwdn_n  <= w_pwdn_n;
         r_rst_n   <= w_rst_n;
         r_xclk_en <= w_xclk_en;
         r_ready   <= w_ready;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_timer <= 16'd0;
         r_presc <= '0;
      end else if (w_next != r_state) begin
         r_timer <= w_load;
         r_presc <= '0;
      end else if (r_timer != 16'd0) begin
         if (r_presc == c_PRE_MAX) begin
            r_presc <= '0;
            r_timer <= r_timer - 16'd1;
         end else begin
            r_presc <= r_presc + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_en       <= 1'b0;
         r_t_pwr    <= c_TPWR_DEF;
         r_t_rdy    <= c_TRDY_DEF;
         r_irq_pend <= 1'b0;
         r_irq_en   <= 1'b0;
      end else begin
         if (w_wr && address == 2'd0) r_en <= writedata[0];
         if (w_wr && address == 2'd2) begin
            r_t_pwr <= writedata[15:0];
            r_t_rdy <= writedata[31:16];
         end
         if (w_wr && address == 2'd3) r_irq_en <= writedata[1];
         // A set on READY entry outranks a simultaneous write-1-to-clear.
         if (w_irq_set) r_irq_pend <= 1'b1;
         else if (w_wr && address == 2'd3 && writedata[0]) r_irq_pend <= 1'b0;
      end
   end

   always_comb begin
      readdata = 32'd0;
      case (address)
         2'd0: readdata = {31'd0, r_en};
         2'd1: readdata = {r_timer, 6'd0, w_busy, r_ready, 5'd0, r_state};
         2'd2: readdata = {r_t_rdy, r_t_pwr};
         2'd3: readdata = {30'd0, r_irq_en, r_irq_pend};
         default: readdata = 32'd0;
      endcase
   end

   assign cam_pwdn_n  = r_pwdn_n;
   assign cam_rst_n   = r_rst_n;
   assign cam_xclk_en = r_xclk_en;
   assign ready       = r_ready;
   assign irq         = r_irq_pend & r_irq_en;

endmodule
`default_nettype wire

// File: tb/tb_soc_system_camera_pwr_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_soc_system_camera_pwr_seq                                  |
// | Function : directed + random bench with a dwell-based reference model    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_soc_system_camera_pwr_seq;

   localparam int c_DIV  = 4;
   localparam int c_TOFF = 2;
   localparam int c_TPWR = 1000;
   localparam int c_TRDY = 20000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  addr = 2'd1;
   logic        cs = 1'b0;
   logic        wn = 1'b1;
   logic [31:0] wdata = 32'd0;
   logic [31:0] readdata;
   logic        cam_pwdn_n, cam_rst_n, cam_xclk_en, ready, irq;

   int checks = 0;
   int failures = 0;

   // Reference model: state plus edges elapsed since entry and the load used.
   int m_state, m_k, m_D, m_tpwr, m_trdy;
   bit m_en, m_pend, m_ien;

   soc_system_camera_pwr_seq #(
      .CLK_DIV  (c_DIV),
      .T_PWR_DEF(c_TPWR),
      .T_RDY_DEF(c_TRDY),
      .T_OFF    (c_TOFF)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (addr),
      .chipselect (cs),
      .write_n    (wn),
      .writedata  (wdata),
      .readdata   (readdata),
      .cam_pwdn_n (cam_pwdn_n),
      .cam_rst_n  (cam_rst_n),
      .cam_xclk_en(cam_xclk_en),
      .ready      (ready),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      m_state = 0; m_k = 0; m_D = 0;
      m_en = 0; m_tpwr = c_TPWR; m_trdy = c_TRDY; m_pend = 0; m_ien = 0;
   endfunction

   function automatic bit timed(input int s);
      return (s == 1) || (s == 2) || (s == 4);
   endfunction

   function automatic int m_timer();
      return timed(m_state) ? (m_D - m_k / c_DIV) : 0;
   endfunction

   function automatic void model_step(input bit wr, input logic [1:0] a, input logic [31:0] d);
      int ns, ld;
      bit done;
      ns   = m_state;
      ld   = 0;
      done = (m_k >= m_D * c_DIV);
      case (m_state)
         0: if (m_en) begin ns = 1; ld = m_tpwr; end
         1, 2, 3: begin
            if (!m_en) begin ns = 4; ld = c_TOFF; end
            else if (m_state == 1 && done) begin ns = 2; ld = m_trdy; end
            else if (m_state == 2 && done) ns = 3;
         end
         4: if (done) ns = 0;
         default: ns = 0;
      endcase
      if (wr) begin
         if (a == 2'd0) m_en = d[0];
         if (a == 2'd2) begin m_tpwr = int'(d[15:0]); m_trdy = int'(d[31:16]); end
         if (a == 2'd3) begin m_ien = d[1]; if (d[0]) m_pend = 0; end
      end
      if (ns == 3 && m_state != 3) m_pend = 1;
      if (ns != m_state) begin m_state = ns; m_k = 0; m_D = ld; end
      else m_k++;
   endfunction

   function automatic logic [31:0] exp_rd(input logic [1:0] a);
      bit busy, rdy;
      busy = timed(m_state);
      rdy  = (m_state == 3);
      case (a)
         2'd0:    return {31'd0, m_en};
         2'd1:    return {16'(m_timer()), 6'd0, busy, rdy, 5'd0, 3'(m_state)};
         2'd2:    return {16'(m_trdy), 16'(m_tpwr)};
         default: return {30'd0, m_ien, m_pend};
      endcase
   endfunction

   function automatic logic [31:0] exp_pins();
      bit p, r, x, y;
      p = (m_state != 0);
      r = (m_state == 2) || (m_state == 3);
      x = (m_state >= 1) && (m_state <= 3);
      y = (m_state == 3);
      return {27'd0, p, r, x, y, m_pend & m_ien};
   endfunction

   function automatic logic [31:0] pins();
      return {27'd0, cam_pwdn_n, cam_rst_n, cam_xclk_en, ready, irq};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      bit wr;
      logic [1:0] a;
      logic [31:0] d;
      wr = cs && !wn; a = addr; d = wdata;
      @(posedge clk);
      model_step(wr, a, d);
      #1;
      chk("pins", pins(), exp_pins());
      chk("readdata", readdata, exp_rd(addr));
   endtask

   task automatic write(input logic [1:0] a, input logic [31:0] d);
      cs = 1'b1; wn = 1'b0; addr = a; wdata = d;
      cycle();
      cs = 1'b0; wn = 1'b1; addr = 2'd1;
   endtask

   // Counts cycles spent in the current state; expects STATUS on the bus.
   task automatic dwell(input string tag, input int exp_n);
      logic [2:0] s0;
      int n;
      #1;
      s0 = readdata[2:0];
      n = 0;
      do begin cycle(); n++; end while (readdata[2:0] === s0 && n < 400);
      chk(tag, n, exp_n);
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s);
      int n;
      #1;
      n = 0;
      while (readdata[2:0] !== s && n < 400) begin cycle(); n++; end
      chk(tag, {29'd0, readdata[2:0]}, {29'd0, s});
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      chk("rst_pins", pins(), 32'd0);
      for (int a = 0; a < 4; a++) begin
         addr = 2'(a);
         #1 chk("rst_reg", readdata, exp_rd(2'(a)));
      end
      chk("rst_delay", {28'd0, 4'(0)} | (addr == 2'd3 ? 32'd0 : 32'd1), 32'd0);
      addr = 2'd2;
      #1 chk("rst_delay_val", readdata, {16'd20000, 16'd1000});
      addr = 2'd1;

      // Full power-up
      write(2'd2, {16'd3, 16'd5});
      write(2'd3, 32'h2);
      write(2'd0, 32'h1);
      cycle();
      chk("pwrup_entry", {29'd0, readdata[2:0]}, 32'd1);
      dwell("pwrup_dwell", 21);
      dwell("rstrel_dwell", 13);
      chk("ready_status", readdata, 32'h103);
      chk("ready_irq", {31'd0, irq}, 32'd1);

      // IRQ clear keeps irq_en
      write(2'd3, 32'h3);
      addr = 2'd3;
      #1 chk("irq_clear", readdata, 32'h2);
      chk("irq_low", {31'd0, irq}, 32'd0);
      addr = 2'd1;

      // Power-down from READY
      write(2'd0, 32'h0);
      cycle();
      chk("shutdn_pins", {29'd0, cam_pwdn_n, cam_rst_n, cam_xclk_en}, 32'b100);
      dwell("shutdn_dwell", 9);
      chk("off_pwdn", {31'd0, cam_pwdn_n}, 32'd0);

      // Abort mid-PWRUP, re-enable during SHUTDN
      write(2'd0, 32'h1);
      cycle();
      repeat (3) cycle();
      write(2'd0, 32'h0);
      cycle();
      chk("abort_shutdn", {29'd0, readdata[2:0]}, 32'd4);
      write(2'd0, 32'h1);
      dwell("shutdn_abort_dwell", 8);
      dwell("off_pass", 1);
      chk("restart_pwrup", {29'd0, readdata[2:0]}, 32'd1);

      // DELAY = 0
      write(2'd0, 32'h0);
      wait_state("to_off_a", 3'd0);
      write(2'd2, 32'h0);
      write(2'd0, 32'h1);
      cycle();
      dwell("pwrup_d0", 1);
      dwell("rstrel_d0", 1);
      chk("ready_d0", {29'd0, readdata[2:0]}, 32'd3);

      // DELAY write mid-PWRUP only affects later entries
      write(2'd0, 32'h0);
      wait_state("to_off_b", 3'd0);
      write(2'd2, {16'd3, 16'd5});
      write(2'd0, 32'h1);
      cycle();
      write(2'd2, {16'd1, 16'd1});
      dwell("pwrup_midwrite", 20);
      dwell("rstrel_newload", 5);

      // Async reset in RSTREL
      write(2'd0, 32'h0);
      wait_state("to_off_c", 3'd0);
      write(2'd2, {16'd3, 16'd5});
      write(2'd0, 32'h1);
      wait_state("to_rstrel", 3'd2);
      @(negedge clk);
      #2 reset_n = 1'b0;
      model_reset();
      #1 chk("async_rst_pins", pins(), 32'd0);
      chk("async_rst_status", readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         int op;
         op = int'($urandom_range(0, 11));
         case (op)
            0, 1:    write(2'd0, {31'd0, 1'($urandom_range(0, 3) != 0)});
            2:       write(2'd2, {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3))});
            3:       write(2'd3, {30'd0, 2'($urandom_range(0, 3))});
            4:       write(2'($urandom_range(0, 3)), $urandom());
            5: begin
               addr = 2'($urandom_range(0, 3));
               cycle();
               addr = 2'd1;
            end
            default: cycle();
         endcase
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
